// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/ifu_pc_sel.sv
// Next-PC select: redirect target beats sequential advance, otherwise hold.
module ifu_pc_sel
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] req_pc_i,
  output logic [ADDR_W-1:0] pc_next_o
);

  // Priority mux; the +4 wraps naturally at the address width
  always_comb begin
    pc_next_o = pc_i;
    if (redirect_i) begin
      pc_next_o = redirect_addr_i;
    end else if (advance_i) begin
      pc_next_o = req_pc_i + ADDR_W'(PC_INC);
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one fetch at a time over a
// valid/ready channel, hands the returned word to decode, and drops any
// response made stale by a redirect.
// Optional: define IFU_PERF_CNT_EN to add perf_fetch_cnt / perf_flush_cnt.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              drop_q, drop_d;
  logic              req_fire;
  logic              advance;

  assign req_fire = (state_q == S_REQ) && imem_req_ready;
  assign advance  = (state_q == S_OUT) && inst_ready;

  // Redirect updates the PC in every state; only a consumed instruction advances it
  ifu_pc_sel #(
    .ADDR_W (ADDR_W)
  ) u_pc_sel (
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .advance_i       (advance),
    .pc_i            (pc_q),
    .req_pc_i        (req_pc_q),
    .pc_next_o       (pc_d)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    inst_d   = inst_q;
    drop_d   = drop_q;
    unique case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
          // A redirect in the accept cycle makes this fetch stale already
          drop_d   = redirect;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect) begin
            state_d = S_REQ;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = S_OUT;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (inst_ready || redirect) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      inst_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      inst_q   <= inst_d;
      drop_q   <= drop_d;
    end
  end

  // Outputs decoded from state; decode sees zeros when nothing is presented
  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = pc_q;
    inst_valid     = (state_q == S_OUT);
    inst           = (state_q == S_OUT) ? inst_q : '0;
    inst_pc        = (state_q == S_OUT) ? req_pc_q : '0;
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;
  logic        rsp_discard, out_flush;

  assign rsp_discard = (state_q == S_WAIT) && imem_rsp_valid && (drop_q || redirect);
  assign out_flush   = (state_q == S_OUT) && redirect && !inst_ready;

  // Free-running event counters, wrap at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (req_fire) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (rsp_discard || out_flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  // Performance counters not built
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: the bench plays instruction memory and decode,
// and tracks fetches as transactions (outstanding fetch, presented
// instruction, next architectural fetch address).
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  ifu_fetch_ctrl #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state
  logic [31:0] m_next;      // address the next fetch must use
  bit          m_out;       // a fetch is outstanding at memory
  bit          m_stale;     // outstanding fetch was overtaken by a redirect
  logic [31:0] m_out_addr;
  int          m_lat;       // cycles until memory answers
  bit          m_have;      // an instruction is presented to decode
  logic [31:0] m_inst_pc;
  int          lat_min = 0;
  int          lat_max = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic idle;
    idle = !(m_out || m_have);
    chk1("req_valid", imem_req_valid, idle);
    if (idle) chk("req_addr", imem_req_addr, m_next);
    chk1("inst_valid", inst_valid, m_have);
    if (m_have) begin
      chk("inst_pc", inst_pc, m_inst_pc);
      chk("inst", inst, mem_word(m_inst_pc));
    end
  endtask

  task automatic model_reset();
    m_next  = RST_PC;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_have  = 1'b0;
    m_lat   = 0;
  endtask

  // One clock: check outputs, drive this cycle's inputs, advance the model
  task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt,
                      input bit irdy, input bit stray);
    bit          fire, rsp;
    logic [31:0] fire_addr;
    check_outputs();
    rsp            = m_out && (m_lat == 0);
    fire           = !(m_out || m_have) && rdy;
    fire_addr      = m_next;
    imem_req_ready = rdy;
    redirect       = redir;
    redirect_addr  = redir ? tgt : $urandom;
    inst_ready     = irdy;
    imem_rsp_valid = rsp || stray;
    imem_rsp_data  = rsp ? mem_word(m_out_addr) : $urandom;
    @(posedge clk);
    #1;
    if (m_out && !rsp) m_lat--;
    if (m_have && (irdy || redir)) begin
      m_have = 1'b0;
      if (!redir) m_next = m_inst_pc + 32'd4;
    end
    if (redir) begin
      m_next  = tgt;
      m_stale = 1'b1;
    end
    if (rsp) begin
      m_out = 1'b0;
      if (!m_stale) begin
        m_have    = 1'b1;
        m_inst_pc = m_out_addr;
      end
    end
    if (fire) begin
      m_out      = 1'b1;
      m_out_addr = fire_addr;
      m_stale    = redir;
      m_lat      = int'($urandom_range(lat_max, lat_min));
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect       = 1'b1;
    redirect_addr  = $urandom;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = $urandom;
    inst_ready     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk1("rst_req_valid", imem_req_valid, 1'b1);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    do_reset();

    // Back-to-back fetches with single-cycle memory and an always-ready decode
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imem_req_addr, RST_PC + 32'(4 * i));
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      chk1("seq_valid", inst_valid, 1'b1);
      chk("seq_pc", inst_pc, RST_PC + 32'(4 * i));
      step(1, 0, 0, 1, 0);
    end

    // Decode stalls for five cycles
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0);
      chk1("stall_req", imem_req_valid, 1'b0);
      chk("stall_pc", inst_pc, 32'h8000_000C);
      chk("stall_inst", inst, mem_word(32'h8000_000C));
    end
    step(1, 0, 0, 1, 0);
    chk("stall_next", imem_req_addr, 32'h8000_0010);

    // Redirect while waiting for memory
    lat_min = 1; lat_max = 1;
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h8000_1000, 0, 0);
    step(0, 0, 0, 0, 0);
    chk1("wait_redir_valid", inst_valid, 1'b0);
    chk("wait_redir_addr", imem_req_addr, 32'h8000_1000);

    // Redirect in the cycle the request is accepted
    lat_min = 0; lat_max = 0;
    step(1, 1, 32'h8000_0100, 0, 0);
    step(0, 0, 0, 0, 0);
    chk1("fire_redir_valid", inst_valid, 1'b0);
    chk("fire_redir_addr", imem_req_addr, 32'h8000_0100);

    // Redirect together with decode acceptance
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk1("out_redir_pre", inst_valid, 1'b1);
    step(0, 1, 32'h8000_0200, 1, 0);
    chk1("out_redir_valid", inst_valid, 1'b0);
    chk("out_redir_addr", imem_req_addr, 32'h8000_0200);

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("wrap_pre", imem_req_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0);
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Reset while a fetch is outstanding, then a late response
    lat_min = 2; lat_max = 2;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 1);
    chk1("late_valid", inst_valid, 1'b0);
    chk1("late_req", imem_req_valid, 1'b1);
    chk("late_addr", imem_req_addr, RST_PC);

    // Randomized traffic
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           (i % 97 == 0) ? 32'hFFFF_FFFC : $urandom,
           $urandom_range(0, 2) != 0, 0);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
